detect_word_packer: RTL
=======================

Name: detect_word_packer

Overview:
- Downstream stage of the serial 2-of-3 majority detector; consumes its Mealy output z, one bit per clock.
- Deserialises qualified z bits LSB-first into WIDTH-bit words and buffers completed words in a 2-entry FIFO.
- Presents the FIFO head on a valid/ready output port to the bus-side consumer.
- Keeps a saturating count of detections (z=1) and of words dropped on overflow.

Parameters:
- WIDTH, 8, bits per packed word (2..32).
- COUNT_W, 16, width of hit_count.
- DROP_W, 8, width of drop_count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- z_in  in  1  detector output bit.
- z_valid  in  1  qualifies z_in this cycle; tie high while the detector free-runs.
- word_data  out  WIDTH  FIFO head word, bit0 = earliest accepted bit.
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  consumer accepts the head when word_valid && word_ready.
- fill_level  out  2  FIFO occupancy: 0, 1 or 2.
- hit_count  out  COUNT_W  accepted bits with z_in=1; saturates at all-ones.
- drop_count  out  DROP_W  completed words discarded because the FIFO was full; saturates.
- overflow  out  1  sticky; set on the first drop, cleared only by reset.

Behaviour:
- Reset, on a clk edge with reset=1: all outputs 0, bit counter 0, shift register 0, FIFO empty. Reset mid-word discards the partial word. Reset wins over every other event in the same cycle.
- Accept: a bit is accepted on each clk edge with z_valid=1. It is written into shift position bit_cnt, and bit_cnt increments. Cycles with z_valid=0 change nothing in the packer.
- Completion: the accepted bit with bit_cnt=WIDTH-1 completes a word, which is the shift contents plus that bit. In the same edge bit_cnt wraps to 0 and the word is pushed. The next accepted bit starts a new word with no gap cycle.
- Latency: word_valid rises on the edge after the completing bit when the FIFO was empty, i.e. 1 cycle.
- Pop: head is removed on any edge with word_valid && word_ready. word_data must be stable while word_valid=1 and word_ready=0.
- FIFO states, with pop = word_valid && word_ready:
  - EMPTY: push -> ONE.
  - ONE: push without pop -> FULL; pop without push -> EMPTY; push with pop -> ONE, new word becomes head.
  - FULL: pop without push -> ONE; push with pop -> FULL, push accepted, order kept; push without pop -> FULL, word dropped.
- Drop: drop_count increments (saturating) and overflow is set. Neither hit_count nor bit_cnt is rolled back.
- hit_count: increments on every accepted bit with z_in=1, whether or not its word is later dropped. Holds at 2^COUNT_W-1.
- The packer makes no assumption about detector warm-up. The detector's first two outputs after reset (always 0) are packed like any other bit.
- fill_level equals FIFO occupancy. word_valid = (fill_level != 0).

Test Plan:
- WIDTH=8, word_ready=1, z_valid=1, z_in = 1,0,1,1,0,0,0,1 -> word_data=0x8D, word_valid high for exactly 1 cycle, on the edge after the 8th bit; hit_count=4.
- z_valid toggled 1,0,1,0... while sending the same 8 bits -> word_data=0x8D, completed on the 8th accepted bit (15th cycle); idle cycles leave bit_cnt unchanged.
- word_ready=0, 24 bits 0xAA, 0x55, 0xFF -> fill_level=2, head=0xAA, 0xFF dropped, drop_count=1, overflow=1; then word_ready=1 -> 0xAA, 0x55 in order; overflow stays 1.
- FIFO full and word_ready=1 in the cycle the 8th bit of a new word 0x3C arrives -> pop and push together, fill_level stays 2, no drop; sequence out is head, second, 0x3C.
- reset asserted after 5 accepted bits, then 8 bits of 0x0F -> output word 0x0F, no stale bits; hit_count=4 (counted from reset).
- COUNT_W=4, 20 accepted z_in=1 bits -> hit_count saturates at 15; DROP_W=2 with 5 forced drops -> drop_count=3.

Source files
------------

// File: rtl/detect_word_packer.sv
// Packs qualified detector bits LSB-first into WIDTH-bit words, buffers them in a
// 2-entry FIFO behind a valid/ready port, and keeps saturating hit/drop counters.
module detect_word_packer #(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 16,
   parameter int DROP_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               z_in,
   input  logic               z_valid,
   output logic [WIDTH-1:0]   word_data,
   output logic               word_valid,
   input  logic               word_ready,
   output logic [1:0]         fill_level,
   output logic [COUNT_W-1:0] hit_count,
   output logic [DROP_W-1:0]  drop_count,
   output logic               overflow
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      FIFO_EMPTY = 2'd0,
      FIFO_ONE   = 2'd1,
      FIFO_FULL  = 2'd2
   } fifo_state_t;

   fifo_state_t        state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [WIDTH-1:0]   slot0_q, slot0_d;
   logic [WIDTH-1:0]   slot1_q, slot1_d;
   logic [COUNT_W-1:0] hit_q, hit_d;
   logic [DROP_W-1:0]  drop_q, drop_d;
   logic               ovf_q, ovf_d;
   logic               push;
   logic               pop;
   logic               drop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FIFO_EMPTY;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         slot0_q   <= '0;
         slot1_q   <= '0;
         hit_q     <= '0;
         drop_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         slot0_q   <= slot0_d;
         slot1_q   <= slot1_d;
         hit_q     <= hit_d;
         drop_q    <= drop_d;
         ovf_q     <= ovf_d;
      end
   end

   // Deserialiser: the completing bit is merged combinationally so the word is
   // pushed on the same edge that accepts its last bit.
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      hit_d     = hit_q;
      push      = 1'b0;
      if (z_valid) begin
         shift_d[bit_cnt_q] = z_in;
         if (z_in && (hit_q != '1)) begin
            hit_d = hit_q + COUNT_W'(1);
         end
         if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            push      = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      drop    = 1'b0;
      pop     = (state_q != FIFO_EMPTY) && word_ready;
      case (state_q)
         FIFO_EMPTY: begin
            if (push) begin
               slot0_d = shift_d;
               state_d = FIFO_ONE;
            end
         end
         FIFO_ONE: begin
            if (push && pop) begin
               slot0_d = shift_d;
            end else if (push) begin
               slot1_d = shift_d;
               state_d = FIFO_FULL;
            end else if (pop) begin
               state_d = FIFO_EMPTY;
            end
         end
         FIFO_FULL: begin
            if (pop) begin
               slot0_d = slot1_q;
               if (push) begin
                  slot1_d = shift_d;
               end else begin
                  state_d = FIFO_ONE;
               end
            end else if (push) begin
               drop = 1'b1;
            end
         end
         default: state_d = FIFO_EMPTY;
      endcase
   end

   always_comb begin
      drop_d = drop_q;
      ovf_d  = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != '1) begin
            drop_d = drop_q + DROP_W'(1);
         end
      end
   end

   assign word_data  = slot0_q;
   assign word_valid = (state_q != FIFO_EMPTY);
   assign fill_level = state_q;
   assign hit_count  = hit_q;
   assign drop_count = drop_q;
   assign overflow   = ovf_q;

endmodule
